// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register offsets,
// STATUS bit positions and the frame deframer state encoding.
package ps2_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;

  localparam int STAT_IE = 7;
  localparam int STAT_FE = 6;
  localparam int STAT_PE = 5;
  localparam int STAT_OV = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2**DEPTH_LOG2 entries, combinational head on dout.
// Caller must not push when full (unless popping) nor pop when empty.
module sync_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [W-1:0]            mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   wptr;
  logic [DEPTH_LOG2-1:0]   rptr;

  assign dout  = mem[rptr];
  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_io.sv
// Memory-mapped PS/2 keyboard receiver: pin sync/filter, 11-bit deframer,
// scancode FIFO and DATA/STATUS/CTRL registers on the I/O page.
module ps2_kbd_io
  import ps2_pkg::*;
#(
  parameter int FILT       = 8,
  parameter int TMO        = 25000,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic        r,
  input  logic [1:0]  w,
  input  logic [15:0] dwrite,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TMO - 1);

  logic [1:0]   clk_sync, dat_sync;
  logic         clk_s, dat_s, clk_f;
  logic [FW-1:0] fcnt;
  logic         fall;

  frame_state_t state;
  logic [2:0]   bitcnt;
  logic [7:0]   shreg;
  logic         par;
  logic [TW-1:0] tmo_cnt;
  logic         tmo_hit, stop_ev, frame_ok, frame_push;

  logic         ie, fe, pe, ov;
  logic         rd_data, st_wr, ctrl_wr;
  logic         fifo_push, fifo_pop, full, empty;
  logic [7:0]   dout;
  logic [DEPTH_LOG2:0] count;
  logic         unused_ok;

  assign unused_ok = ^{dwrite[15:7], dwrite[3:1], w[1]};

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Filtered clock flips only after FILT consecutive samples disagree with it.
  assign fall = clk_f & ~clk_s & (fcnt == FILT_MAX);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      clk_f <= 1'b1;
      fcnt  <= '0;
    end else if (clk_s == clk_f) begin
      fcnt <= '0;
    end else if (fcnt == FILT_MAX) begin
      clk_f <= clk_s;
      fcnt  <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign tmo_hit    = (state != IDLE) & ~fall & (tmo_cnt == TMO_MAX);
  assign stop_ev    = (state == STOP) & fall;
  assign frame_ok   = ^{par, shreg};
  assign frame_push = stop_ev & dat_s & frame_ok;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= (state == IDLE || fall) ? '0 : tmo_cnt + 1'b1;
      if (tmo_hit) begin
        state <= IDLE;
      end else if (fall) begin
        unique case (state)
          IDLE: if (!dat_s) begin
            state  <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            shreg  <= {dat_s, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s;
            state <= STOP;
          end
          STOP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rd_data = sel & r & (addr == REG_DATA);
  assign st_wr   = sel & w[0] & (addr == REG_STATUS);
  assign ctrl_wr = sel & w[0] & (addr == REG_CTRL);

  assign fifo_pop  = rd_data & ~empty;
  assign fifo_push = frame_push & (~full | fifo_pop);

  sync_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (shreg),
    .dout   (dout),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Hardware set takes priority over a software clear in the same cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ie <= 1'b0;
      fe <= 1'b0;
      pe <= 1'b0;
      ov <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= dwrite[0];
      fe <= (stop_ev & ~dat_s) | tmo_hit | (fe & ~(st_wr & dwrite[STAT_FE]));
      pe <= (stop_ev & ~frame_ok) | (pe & ~(st_wr & dwrite[STAT_PE]));
      ov <= (frame_push & full & ~fifo_pop) | (ov & ~(st_wr & dwrite[STAT_OV]));
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        REG_DATA:   if (!empty) rdata = {1'b1, 7'b0, dout};
        REG_STATUS: begin
          rdata[STAT_IE] = ie;
          rdata[STAT_FE] = fe;
          rdata[STAT_PE] = pe;
          rdata[STAT_OV] = ov;
          rdata[3:0]     = 4'(count);
        end
        REG_CTRL:   rdata[0] = ie;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = ie & (~empty | fe | pe | ov);

endmodule
